// File: rtl/led_pwm_driver.sv
`default_nettype none
//==============================================================================
// Module   : led_pwm_driver
// Desc     : LED pattern driver with global PWM dimming and per-LED blinking.
// Revision : 1.0 - initial release
//==============================================================================
module led_pwm_driver #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE      = 50,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [WIDTH-1:0]    blink_mask,
  output logic [WIDTH-1:0]    led_out,
  output logic                period_start,
  output logic                blink_phase
);

  localparam int c_PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_PERIODS - 1);

  logic [c_PRESC_W-1:0] r_presc;
  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic [WIDTH-1:0]     r_led_sh;
  logic [PWM_BITS-1:0]  r_bright_sh;
  logic [WIDTH-1:0]     r_mask_sh;
  logic [WIDTH-1:0]     r_led_out;
  logic                 r_period_start;
  logic                 r_blink_phase;

  logic                 w_tick;
  logic                 w_period_end;
  logic                 w_pwm_on;
  logic [WIDTH-1:0]     w_led_next;

  assign w_tick       = enable & (r_presc == c_PRESC_LAST);
  assign w_period_end = w_tick & (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign w_pwm_on     = (r_pwm_cnt < r_bright_sh);
  // Blinking LEDs are gated by the phase; non-blinking LEDs ignore it.
  assign w_led_next   = {WIDTH{w_pwm_on}} & r_led_sh & (~r_mask_sh | {WIDTH{r_blink_phase}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc        <= '0;
      r_pwm_cnt      <= '0;
      r_blink_cnt    <= '0;
      r_led_sh       <= '0;
      r_bright_sh    <= '0;
      r_mask_sh      <= '0;
      r_led_out      <= '0;
      r_period_start <= 1'b0;
      r_blink_phase  <= 1'b1;
    end else if (!enable) begin
      // Shadows track the inputs so the first enabled period uses fresh values.
      r_presc        <= '0;
      r_pwm_cnt      <= '0;
      r_blink_cnt    <= '0;
      r_led_sh       <= led_in;
      r_bright_sh    <= brightness;
      r_mask_sh      <= blink_mask;
      r_led_out      <= '0;
      r_period_start <= 1'b0;
      r_blink_phase  <= 1'b1;
    end else begin
      r_presc        <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
      r_period_start <= w_period_end;
      r_led_out      <= w_led_next;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
      if (w_period_end) begin
        r_led_sh    <= led_in;
        r_bright_sh <= brightness;
        r_mask_sh   <= blink_mask;
        if (r_blink_cnt == c_BLINK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
      end
    end
  end

  assign led_out      = r_led_out;
  assign period_start = r_period_start;
  assign blink_phase  = r_blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_led_pwm_driver
// Desc     : Self-checking bench for led_pwm_driver (16-clk PWM period).
// Revision : 1.0 - initial release
//==============================================================================
module tb_led_pwm_driver;

  localparam int P   = 2;
  localparam int B   = 3;
  localparam int BP  = 2;
  localparam int T   = 8;
  localparam int PER = P * T;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [2:0] brightness = 3'd0;
  logic [7:0] blink_mask = 8'h00;
  logic [7:0] led_out;
  logic       period_start;
  logic       blink_phase;

  int n_cmp = 0;
  int n_bad = 0;

  led_pwm_driver #(
    .WIDTH(8), .PRESCALE(P), .PWM_BITS(B), .BLINK_PERIODS(BP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .led_in(led_in),
    .brightness(brightness), .blink_mask(blink_mask), .led_out(led_out),
    .period_start(period_start), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: n counts enabled clock edges since the last restart.
  function automatic bit phase_of(input int n);
    return (((n / PER) / BP) % 2) == 0;
  endfunction

  function automatic bit is_pend(input int n);
    return ((n + 1) % PER) == 0;
  endfunction

  function automatic logic [7:0] model_led(input int n, input logic [7:0] l,
                                           input logic [2:0] b, input logic [7:0] m);
    int  pwm;
    bit  ph;
    pwm = (n / P) % T;
    ph  = phase_of(n);
    return (pwm < int'(b)) ? (l & (~m | {8{ph}})) : 8'h00;
  endfunction

  int         m_n = 0;
  logic [7:0] m_led = 8'h00;
  logic [2:0] m_bri = 3'd0;
  logic [7:0] m_mask = 8'h00;
  logic [7:0] exp_led = 8'h00;
  logic       exp_ps = 1'b0;
  logic       exp_phase = 1'b1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n <= 0; m_led <= 8'h00; m_bri <= 3'd0; m_mask <= 8'h00;
      exp_led <= 8'h00; exp_ps <= 1'b0; exp_phase <= 1'b1;
    end else if (!enable) begin
      m_n <= 0; m_led <= led_in; m_bri <= brightness; m_mask <= blink_mask;
      exp_led <= 8'h00; exp_ps <= 1'b0; exp_phase <= 1'b1;
    end else begin
      exp_led   <= model_led(m_n, m_led, m_bri, m_mask);
      exp_ps    <= is_pend(m_n);
      exp_phase <= phase_of(m_n + 1);
      m_n       <= m_n + 1;
      if (is_pend(m_n)) begin
        m_led <= led_in; m_bri <= brightness; m_mask <= blink_mask;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_led", 32'(led_out), 32'(exp_led));
      check("model_pstart", 32'(period_start), 32'(exp_ps));
      check("model_phase", 32'(blink_phase), 32'(exp_phase));
    end
  end

  typedef struct {
    logic [7:0] led;
    logic [7:0] mask;
    logic [2:0] bri;
    logic [7:0] exp_pat;
    int         exp_on;
    bit         exp_ph;
  } vec_t;

  vec_t tbl[16];

  // One PWM period of samples: applies v's inputs mid-period, checks v's expectation.
  task automatic run_window(input vec_t v);
    int shape_err = 0;
    int ps_err = 0;
    for (int k = 0; k < PER; k++) begin
      @(negedge clk);
      if (k == 0) check("win_phase", 32'(blink_phase), 32'(v.exp_ph));
      if (led_out !== ((k < v.exp_on) ? v.exp_pat : 8'h00)) shape_err++;
      if (period_start !== (k == PER - 1)) ps_err++;
      if (k == 5) begin
        led_in = v.led; blink_mask = v.mask; brightness = v.bri;
      end
    end
    check("win_shape", 32'(shape_err), 32'd0);
    check("win_pstart", 32'(ps_err), 32'd0);
  endtask

  initial begin
    int first;
    bit seen;
    tbl[0]  = '{8'hFF, 8'h00, 3'd4, 8'h00, 0,  1'b1};
    tbl[1]  = '{8'h0F, 8'h00, 3'd4, 8'hFF, 8,  1'b1};
    tbl[2]  = '{8'hF0, 8'h00, 3'd7, 8'h0F, 8,  1'b0};
    tbl[3]  = '{8'hFF, 8'h00, 3'd0, 8'hF0, 14, 1'b0};
    tbl[4]  = '{8'hFF, 8'h00, 3'd0, 8'h00, 0,  1'b1};
    tbl[5]  = '{8'hFF, 8'h00, 3'd0, 8'h00, 0,  1'b1};
    tbl[6]  = '{8'hFF, 8'h00, 3'd0, 8'h00, 0,  1'b0};
    tbl[7]  = '{8'hFF, 8'h00, 3'd7, 8'h00, 0,  1'b0};
    tbl[8]  = '{8'hFF, 8'h00, 3'd7, 8'hFF, 14, 1'b1};
    tbl[9]  = '{8'h03, 8'h01, 3'd7, 8'hFF, 14, 1'b1};
    tbl[10] = '{8'h03, 8'h01, 3'd7, 8'h02, 14, 1'b0};
    tbl[11] = '{8'h03, 8'h01, 3'd7, 8'h02, 14, 1'b0};
    tbl[12] = '{8'h03, 8'h01, 3'd7, 8'h03, 14, 1'b1};
    tbl[13] = '{8'h03, 8'h01, 3'd7, 8'h03, 14, 1'b1};
    tbl[14] = '{8'h03, 8'h01, 3'd7, 8'h02, 14, 1'b0};
    tbl[15] = '{8'h03, 8'h01, 3'd7, 8'h02, 14, 1'b0};

    enable = 1'b1; led_in = 8'hFF; brightness = 3'd4; blink_mask = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_pstart", 32'(period_start), 32'd0);
      check("rst_phase", 32'(blink_phase), 32'd1);
    end
    reset_n = 1'b1;
    for (int p = 0; p < 16; p++) run_window(tbl[p]);

    // Enable drop mid-period, re-enable after three disabled edges.
    led_in = 8'hFF; brightness = 3'd4; blink_mask = 8'h00;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_led", 32'(led_out), 32'd0);
    check("dis_pstart", 32'(period_start), 32'd0);
    check("dis_phase", 32'(blink_phase), 32'd1);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    first = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (period_start === 1'b1 && first == 0) first = j;
      if (first != 0) break;
    end
    check("reen_pstart_lat", 32'(first), 32'd16);

    // Async reset while blink_phase is 0 and LEDs are lit.
    seen = 1'b0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      if (blink_phase === 1'b0) begin seen = 1'b1; break; end
    end
    check("wait_phase0", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check("pre_rst_led", 32'(led_out), 32'hFF);
    #2 reset_n = 1'b0;
    #1;
    check("arst_led", 32'(led_out), 32'd0);
    check("arst_pstart", 32'(period_start), 32'd0);
    check("arst_phase", 32'(blink_phase), 32'd1);
    repeat (3) @(negedge clk);
    check("arst_hold_led", 32'(led_out), 32'd0);
    reset_n = 1'b1;
    run_window('{8'hFF, 8'h00, 3'd4, 8'h00, 0, 1'b1});
    run_window('{8'hFF, 8'h00, 3'd4, 8'hFF, 8, 1'b1});
    run_window('{8'hFF, 8'h00, 3'd4, 8'hFF, 8, 1'b0});

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 8) led_in = 8'($urandom);
      if ($urandom_range(0, 99) < 6) brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 5) blink_mask = 8'($urandom);
      if (!enable) begin
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        enable = 1'b0;
      end
      if ($urandom_range(0, 999) < 3) begin
        #2 reset_n = 1'b0;
        #1;
        check("rnd_arst_led", 32'(led_out), 32'd0);
        check("rnd_arst_phase", 32'(blink_phase), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
